// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - five-stage pipeline hazard/sequencing controller
// Owns PC and pipeline-register write enables/flushes, plus debug stall/flush counters.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_req,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_wsel,
  input  logic             ex_redirect,
  input  logic             wb_halt,
  output logic             pc_W,
  output logic             ifid_W,
  output logic             ifid_RST,
  output logic             idex_W,
  output logic             idex_RST,
  output logic             exmem_W,
  output logic             memwb_W,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALTED  = 2'd2
  } state_t;

  state_t state, next_state;
  logic   squash_pend, squash_next;
  logic   halt_next;
  logic   flush_inc;
  logic   load_use;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  assign load_use = ex_memread && (ex_wsel != 5'd0) &&
                    ((ex_wsel == id_rs) || (ex_wsel == id_rt));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= RUN;
      squash_pend <= 1'b0;
      halt        <= 1'b0;
    end else begin
      state       <= next_state;
      squash_pend <= squash_next;
      halt        <= halt_next;
    end
  end

  always_comb begin
    pc_W        = 1'b0;
    ifid_W      = 1'b0;
    ifid_RST    = 1'b0;
    idex_W      = 1'b0;
    idex_RST    = 1'b0;
    exmem_W     = 1'b0;
    memwb_W     = 1'b0;
    next_state  = state;
    squash_next = squash_pend;
    halt_next   = halt;
    flush_inc   = 1'b0;
    if (!nRST) begin
      ifid_RST = 1'b1;
      idex_RST = 1'b1;
    end else begin
      case (state)
        RUN, MEMWAIT: begin
          if (wb_halt) begin
            next_state = HALTED;
            halt_next  = 1'b1;
          end else if (mem_req && !dhit) begin
            // Whole pipe freezes; redirect and load-use wait until dhit.
            next_state = MEMWAIT;
          end else begin
            next_state = RUN;
            if (ex_redirect) begin
              pc_W        = 1'b1;
              ifid_RST    = 1'b1;
              idex_RST    = 1'b1;
              exmem_W     = 1'b1;
              memwb_W     = 1'b1;
              squash_next = !ihit;
              flush_inc   = 1'b1;
            end else if (load_use) begin
              idex_RST = 1'b1;
              exmem_W  = 1'b1;
              memwb_W  = 1'b1;
            end else begin
              idex_W  = 1'b1;
              exmem_W = 1'b1;
              memwb_W = 1'b1;
              if (squash_pend) begin
                // Late wrong-path fetch returning; PC already holds the target.
                ifid_RST = 1'b1;
                if (ihit) squash_next = 1'b0;
              end else if (ihit) begin
                pc_W   = 1'b1;
                ifid_W = 1'b1;
              end else begin
                ifid_RST = 1'b1;
              end
            end
          end
        end
        default: begin
          next_state = HALTED;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state != HALTED) begin
      if (!pc_W && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  localparam int CNT_W = 4;

  logic CLK = 1'b0;
  logic nRST, ihit, dhit, mem_req, ex_memread, ex_redirect, wb_halt;
  logic [4:0] id_rs, id_rt, ex_wsel;
  logic pc_W, ifid_W, ifid_RST, idex_W, idex_RST, exmem_W, memwb_W, halt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [6:0] ctl;

  int n_checks = 0;
  int n_fail = 0;

  // {pc_W, ifid_W, ifid_RST, idex_W, idex_RST, exmem_W, memwb_W}
  localparam logic [6:0] C_ADV   = 7'b1101011;
  localparam logic [6:0] C_FRZ   = 7'b0000000;
  localparam logic [6:0] C_RST   = 7'b0010100;
  localparam logic [6:0] C_LU    = 7'b0000111;
  localparam logic [6:0] C_REDIR = 7'b1010111;
  localparam logic [6:0] C_BUB   = 7'b0011011;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread), .ex_wsel(ex_wsel),
    .ex_redirect(ex_redirect), .wb_halt(wb_halt),
    .pc_W(pc_W), .ifid_W(ifid_W), .ifid_RST(ifid_RST), .idex_W(idex_W),
    .idex_RST(idex_RST), .exmem_W(exmem_W), .memwb_W(memwb_W), .halt(halt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign ctl = {pc_W, ifid_W, ifid_RST, idex_W, idex_RST, exmem_W, memwb_W};

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic cnts(input string tag, input int s, input int f);
    check({tag, "_stall"}, 32'(stall_cnt), s);
    check({tag, "_flush"}, 32'(flush_cnt), f);
  endtask

  initial begin
    nRST = 0; ihit = 1; dhit = 0; mem_req = 0; ex_memread = 0; ex_redirect = 0;
    wb_halt = 0; id_rs = 0; id_rt = 0; ex_wsel = 0;
    #2;
    check("reset_ctl", 32'(ctl), 32'(C_RST));
    check("reset_halt", 32'(halt), 0);
    cnts("reset", 0, 0);
    tick();
    nRST = 1;
    #1;
    check("post_reset_ctl", 32'(ctl), 32'(C_ADV));
    tick();
    check("adv_ctl", 32'(ctl), 32'(C_ADV));
    cnts("adv", 0, 0);

    // load-use on rt, then rs, then ex_wsel=0 (no hazard)
    ex_memread = 1; ex_wsel = 5; id_rt = 5; #1;
    check("lu_rt_ctl", 32'(ctl), 32'(C_LU));
    tick();
    cnts("lu_rt", 1, 0);
    id_rt = 0; id_rs = 5; #1;
    check("lu_rs_ctl", 32'(ctl), 32'(C_LU));
    tick();
    cnts("lu_rs", 2, 0);
    ex_wsel = 0; id_rs = 0; id_rt = 0; #1;
    check("lu_r0_ctl", 32'(ctl), 32'(C_ADV));
    tick();
    ex_memread = 0;
    cnts("lu_r0", 2, 0);

    // dcache miss for 4 cycles, then hit
    mem_req = 1; dhit = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("miss_ctl", 32'(ctl), 32'(C_FRZ));
      tick();
    end
    cnts("miss", 6, 0);
    dhit = 1; #1;
    check("miss_done_ctl", 32'(ctl), 32'(C_ADV));
    tick();
    mem_req = 0; dhit = 0;
    cnts("miss_done", 6, 0);

    // redirect with ihit=0, wrong-path fetch returns after 2 cycles
    ex_redirect = 1; ihit = 0; #1;
    check("redir_ctl", 32'(ctl), 32'(C_REDIR));
    tick();
    ex_redirect = 0;
    cnts("redir", 6, 1);
    for (int i = 0; i < 3; i++) begin
      ihit = (i == 2); #1;
      check("squash_ctl", 32'(ctl), 32'(C_BUB));
      tick();
    end
    ihit = 1; #1;
    check("after_squash_ctl", 32'(ctl), 32'(C_ADV));
    tick();
    cnts("squash", 9, 1);

    // redirect held under a freeze, accepted when dhit arrives
    ex_redirect = 1; mem_req = 1; dhit = 0; #1;
    check("frz_redir_ctl", 32'(ctl), 32'(C_FRZ));
    tick();
    cnts("frz_redir", 10, 1);
    dhit = 1; #1;
    check("frz_redir_hit_ctl", 32'(ctl), 32'(C_REDIR));
    tick();
    mem_req = 0; dhit = 0; ex_redirect = 0;
    cnts("frz_redir_hit", 10, 2);
    #1;
    check("frz_redir_next_ctl", 32'(ctl), 32'(C_ADV));

    // redirect beats load-use
    ex_redirect = 1; ex_memread = 1; ex_wsel = 7; id_rs = 7; #1;
    check("redir_lu_ctl", 32'(ctl), 32'(C_REDIR));
    tick();
    ex_redirect = 0; ex_memread = 0; ex_wsel = 0; id_rs = 0;
    cnts("redir_lu", 10, 3);

    // plain fetch bubble
    ihit = 0; #1;
    check("fetch_bubble_ctl", 32'(ctl), 32'(C_BUB));
    tick();
    cnts("fetch_bubble", 11, 3);

    // halt
    wb_halt = 1; ihit = 1; #1;
    check("halt_ctl", 32'(ctl), 32'(C_FRZ));
    tick();
    wb_halt = 0; dhit = 1;
    check("halt_set", 32'(halt), 1);
    for (int i = 0; i < 3; i++) begin
      check("halted_ctl", 32'(ctl), 32'(C_FRZ));
      tick();
    end
    cnts("halted", 12, 3);
    #2; nRST = 0; #1;
    check("halt_clear", 32'(halt), 0);
    cnts("halt_clear", 0, 0);
    tick();
    nRST = 1; dhit = 0;

    // counter saturation
    ihit = 0;
    for (int i = 0; i < 20; i++) tick();
    cnts("stall_sat", 15, 0);
    ihit = 1; ex_redirect = 1;
    for (int i = 0; i < 20; i++) tick();
    cnts("flush_sat", 15, 15);
    ex_redirect = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage MIPS pipeline. It owns the write-enable and flush of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It decides each cycle whether stages advance, freeze, or take a bubble, based on cache hits, load-use hazards, control redirects and halt. It also keeps saturating stall and flush counters for debug.

## Interface
- CNT_W, 16, width of the performance counters.

- CLK  in  1  system clock; all state updates on rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- ihit  in  1  icache has a valid instruction for the current PC this cycle.
- dhit  in  1  dcache completed the MEM-stage access this cycle.
- mem_req  in  1  instruction in MEM is a load or store (dmemREN|dmemWEN).
- id_rs  in  5  rs field of the instruction in ID (IF/ID idrsel1).
- id_rt  in  5  rt field of the instruction in ID (IF/ID idrsel2).
- ex_memread  in  1  instruction in EX is a load.
- ex_wsel  in  5  destination register of the instruction in EX.
- ex_redirect  in  1  taken branch or jump resolved in EX; the PC mux selects the target.
- wb_halt  in  1  halt instruction is in WB.
- pc_W  out  1  PC write enable.
- ifid_W  out  1  IF/ID write enable (ifW).
- ifid_RST  out  1  IF/ID flush to nop (ifRST); wins over ifid_W.
- idex_W  out  1  ID/EX write enable.
- idex_RST  out  1  ID/EX flush to bubble; wins over idex_W.
- exmem_W  out  1  EX/MEM write enable.
- memwb_W  out  1  MEM/WB write enable.
- halt  out  1  sticky halted indication.
- stall_cnt  out  CNT_W  cycles with pc_W=0 while not halted, saturating.
- flush_cnt  out  CNT_W  accepted redirects, saturating.

## Operation
- State register: RUN, MEMWAIT, HALTED. Separate flag squash_pend.
- Register reset values: state=RUN, squash_pend=0, halt=0, counters=0.
- Outputs while nRST=0: all *_W=0, ifid_RST=1, idex_RST=1.

Outputs in RUN or MEMWAIT are evaluated in priority order; the first match wins.
1. wb_halt=1:
   - all *_W=0; next state HALTED.
2. mem_req & !dhit (freeze):
   - all *_W=0, no RST; next state MEMWAIT.
   - Redirect and load-use are not evaluated; they are re-evaluated after the freeze.
3. ex_redirect=1:
   - pc_W=1, ifid_RST=1, idex_RST=1, exmem_W=memwb_W=1.
   - squash_pend <= !ihit; flush_cnt++.
4. Load-use (ex_memread & ex_wsel!=0 & (ex_wsel==id_rs | ex_wsel==id_rt)):
   - pc_W=0, ifid_W=0, idex_RST=1, exmem_W=memwb_W=1.
5. Normal advance:
   - idex_W=exmem_W=memwb_W=1.
   - If squash_pend: pc_W=0, ifid_RST=1. If ihit, also clear squash_pend (this is a wrong-path return; the PC already holds the target).
   - Else if ihit: pc_W=1, ifid_W=1.
   - Else: pc_W=0, ifid_RST=1 (fetch bubble).

State transitions:
- In MEMWAIT, dhit=1 returns the state to RUN. That same cycle, outputs follow rules 3-5.
- HALTED: all *_W=0, halt=1, counters frozen. The only exit is nRST.

Counters:
- stall_cnt increments every non-HALTED cycle with pc_W=0, including during the freeze.
- Both counters saturate at 2^CNT_W-1; there is no wrap.

## Timing
- Control outputs are combinational from the current state, squash_pend and the inputs, with zero-cycle latency. halt, squash_pend and the counters are registered and update on the next edge.
- Load-use costs exactly one bubble. On the next cycle the load is in MEM and forwarding covers the dependency.
- A redirect costs two flushed slots (IF/ID and ID/EX), plus any squashed wrong-path ihit.
- Simultaneous redirect and load-use: the redirect wins, and the ID instruction is flushed anyway.
- Simultaneous freeze and redirect: the freeze wins. ex_redirect is held by the frozen EX stage and is accepted when dhit arrives.
- If nRST asserts mid-freeze or mid-squash, all state clears immediately.

## Test plan
- Reset with ihit=1: nRST low gives ifid_RST=1 and all W=0. One cycle after nRST rises, pc_W=1, ifid_W=1, and both counters read 0.
- Load-use: ex_memread=1, ex_wsel=5, id_rt=5 for one cycle gives pc_W=0, ifid_W=0, idex_RST=1, stall_cnt=1. With ex_wsel=0 there is no stall.
- dcache miss: mem_req=1, dhit=0 for 4 cycles, then dhit=1. All W=0 for 4 cycles, state MEMWAIT, stall_cnt=4; the dhit cycle advances the pipeline.
- Redirect with ihit=0: ifid_RST=idex_RST=1, pc_W=1. Then ihit=0 for 2 cycles and ihit=1 gives ifid_RST=1 and pc_W=0 on all three cycles. The following ihit writes IF/ID; flush_cnt=1.
- Redirect together with mem_req & !dhit: no flush until dhit, then a single flush and flush_cnt=1.
- wb_halt=1: halt=1 on the next edge, all W=0 thereafter regardless of ihit/dhit; nRST clears halt.
